// File: rtl/debounce_events.sv
// debounce_events
//   Multi-channel switch/key debouncer and event generator. Every channel is
//   passed through a 2-FF synchroniser, optionally inverted (active-low pins),
//   then qualified against a shared prescaled timebase. Each channel produces a
//   debounced level plus single-cycle press, release and long-press pulses.
//
//   Optional feature macro: DEBOUNCE_AUTOREPEAT_EN
//     defined   : after long_press, repeat_pulse fires every REPEAT_TICKS ticks
//                 while the channel stays pressed.
//     undefined : repeat_pulse is tied to 0 and no repeat counters exist.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   button_in    raw asynchronous pin levels, one bit per channel
//   state        debounced level (1 = pressed/on after inversion)
//   rise         1-cycle pulse on state 0->1
//   fall         1-cycle pulse on state 1->0
//   long_press   1-cycle pulse once state has been 1 for LONG_TICKS ticks
//   repeat_pulse 1-cycle auto-repeat pulse (0 unless DEBOUNCE_AUTOREPEAT_EN)
module debounce_events #(
  parameter int unsigned       NUM_CH       = 22,
  parameter int unsigned       TICK_DIV     = 2500,
  parameter int unsigned       STABLE_TICKS = 4,
  parameter int unsigned       LONG_TICKS   = 20000,
  parameter int unsigned       REPEAT_TICKS = 4000,
  parameter logic [NUM_CH-1:0] INVERT_MASK  = 22'h00000F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] state,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] repeat_pulse
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_TICKS);
  localparam logic [HW-1:0] LONG_MAX   = HW'(LONG_TICKS);
  localparam logic [HW-1:0] LONG_LAST  = HW'(LONG_TICKS - 1);

  if (TICK_DIV < 1 || STABLE_TICKS < 1 || LONG_TICKS <= STABLE_TICKS ||
      REPEAT_TICKS < 1) begin : g_bad_params
    $error("debounce_events: illegal parameter combination");
  end

  logic [PW-1:0]     pre;
  logic              tick;
  logic [NUM_CH-1:0] sync1, sync2, s, prev;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] release_now;
  logic [CW-1:0]     cnt  [NUM_CH];
  logic [HW-1:0]     hold [NUM_CH];

  // Shared timebase; with TICK_DIV == 1 the counter stays at 0 and tick is
  // permanently high.
  assign tick = (pre == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset || tick) pre <= '0;
    else               pre <= pre + PW'(1);
  end

  // Synchroniser resets to the idle pin level so inverted channels do not see
  // a spurious edge on reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= INVERT_MASK;
      sync2 <= INVERT_MASK;
      prev  <= '0;
    end else begin
      sync1 <= button_in;
      sync2 <= sync1;
      prev  <= s;
    end
  end

  assign s = sync2 ^ INVERT_MASK;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      accept[i] = (cnt[i] == STABLE_MAX) && (s[i] == prev[i]) && (s[i] != state[i]);
  end

  assign release_now = accept & ~s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= '0;
      rise       <= '0;
      fall       <= '0;
      long_press <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        hold[i] <= '0;
      end
    end else begin
      // accept[i] already implies s[i] != state[i], so the update is a toggle.
      state <= state ^ accept;
      rise  <= accept & s;
      fall  <= release_now;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (s[i] != prev[i])
          cnt[i] <= '0;
        else if (tick && cnt[i] < STABLE_MAX)
          cnt[i] <= cnt[i] + CW'(1);

        // long_press fires on the same edge that hold saturates, so it cannot
        // repeat until hold is cleared by a release.
        long_press[i] <= 1'b0;
        if (!state[i] || release_now[i]) begin
          hold[i] <= '0;
        end else if (tick && hold[i] < LONG_MAX) begin
          hold[i] <= hold[i] + HW'(1);
          long_press[i] <= (hold[i] == LONG_LAST);
        end
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned   RW       = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep [NUM_CH];

  // Counting starts on the first tick after hold saturated, so the first
  // repeat lands exactly REPEAT_TICKS ticks after long_press.
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_pulse <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) rep[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        repeat_pulse[i] <= 1'b0;
        if (!state[i] || release_now[i]) begin
          rep[i] <= '0;
        end else if (tick && hold[i] == LONG_MAX) begin
          if (rep[i] == REP_LAST) begin
            rep[i]          <= '0;
            repeat_pulse[i] <= 1'b1;
          end else begin
            rep[i] <= rep[i] + RW'(1);
          end
        end
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_events.sv
// tb_debounce_events
//   Scoreboard bench for debounce_events. Each scenario pushes the pulses it
//   expects (kind, channel, cycle window) when it drives the pins; a collector
//   records every pulse the DUT emits, and the scenario pops and compares both
//   queues in order. Ports/parameters follow the small bench configuration.
module tb_debounce_events;

  localparam int unsigned NUM_CH = 4;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic [NUM_CH-1:0] button_in = 4'b1000;
  logic [NUM_CH-1:0] state, rise, fall, long_press, repeat_pulse;

  debounce_events #(
    .NUM_CH      (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .LONG_TICKS  (10),
    .REPEAT_TICKS(3),
    .INVERT_MASK (4'b1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_in   (button_in),
    .state       (state),
    .rise        (rise),
    .fall        (fall),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int ch; int lo; int hi; } exp_t;
  typedef struct { int kind; int ch; int cyc; } obs_t;

  exp_t  expq[$];
  obs_t  obsq[$];
  int    tests     = 0;
  int    fails     = 0;
  int    last_long = -1;
  int    both_err  = 0;
  int    press_cyc = 0;
  int    rise0_cyc = -1000;
  string kname [4] = '{"rise", "fall", "long_press", "repeat_pulse"};

  // Records every pulse seen at negedges; kinds: 0 rise, 1 fall, 2 long, 3 repeat.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (rise[ch])         obsq.push_back(obs_t'{0, ch, cyc});
        if (fall[ch])         obsq.push_back(obs_t'{1, ch, cyc});
        if (long_press[ch]) begin
          obsq.push_back(obs_t'{2, ch, cyc});
          last_long = cyc;
        end
        if (repeat_pulse[ch]) obsq.push_back(obs_t'{3, ch, cyc});
        if (rise[ch] && fall[ch]) both_err++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    button_in = 4'b1000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++; if (state !== 4'b0000)        begin fails++; $display("FAIL reset_state: got %b, required 0000", state); end
    tests++; if (rise !== 4'b0000)         begin fails++; $display("FAIL reset_rise: got %b, required 0000", rise); end
    tests++; if (fall !== 4'b0000)         begin fails++; $display("FAIL reset_fall: got %b, required 0000", fall); end
    tests++; if (long_press !== 4'b0000)   begin fails++; $display("FAIL reset_long: got %b, required 0000", long_press); end
    tests++; if (repeat_pulse !== 4'b0000) begin fails++; $display("FAIL reset_repeat: got %b, required 0000", repeat_pulse); end
  endtask

  task automatic test_clean_press();
    exp_t e; obs_t o; int mc[$]; int c0;
    @(posedge clk); #1 button_in[0] = 1'b1; c0 = cyc;
    press_cyc = c0;
    expq.push_back(exp_t'{0, 0, c0 + 10, c0 + 16});
    collect(20);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL clean_press: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL clean_press: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL clean_press_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
    if (mc.size() > 0) rise0_cyc = mc[0];
    tests++; if (state[0] !== 1'b1) begin fails++; $display("FAIL clean_press_state: got %b, required 1", state[0]); end
  endtask

  task automatic test_long_press();
    exp_t e; obs_t o; int mc[$]; int lcyc; int rel;
    last_long = -1;
    expq.push_back(exp_t'{2, 0, press_cyc + 47, press_cyc + 56});
`ifdef DEBOUNCE_AUTOREPEAT_EN
    for (int k = 1; k <= 3; k++)
      expq.push_back(exp_t'{3, 0, press_cyc + 47 + 12 * k, press_cyc + 56 + 12 * k});
`endif
    while (last_long < 0 && cyc < press_cyc + 70) collect(1);
    lcyc = (last_long < 0) ? cyc : last_long;
    // Release timed so the fall lands between the third and fourth repeat slots.
    while (cyc < lcyc + 28) collect(1);
    @(posedge clk); #1 button_in[0] = 1'b0; rel = cyc;
    expq.push_back(exp_t'{1, 0, rel + 10, rel + 16});
    collect(20);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL long_press: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL long_press: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL long_press_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
    if (mc.size() > 0) begin
      tests++;
      if (mc[0] - rise0_cyc < 37 || mc[0] - rise0_cyc > 40) begin
        fails++; $display("FAIL long_press_delay: got %0d cycles after rise, required 37..40", mc[0] - rise0_cyc);
      end
    end
`ifdef DEBOUNCE_AUTOREPEAT_EN
    if (mc.size() >= 4) begin
      for (int k = 1; k <= 3; k++) begin
        tests++;
        if (mc[k] - mc[0] != 12 * k) begin
          fails++; $display("FAIL repeat_spacing%0d: got %0d cycles after long_press, required %0d", k, mc[k] - mc[0], 12 * k);
        end
      end
    end
`endif
  endtask

  task automatic test_bounce();
    exp_t e; obs_t o; int mc[$]; int c0; int bad;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1 button_in[1] = ~button_in[1];
      for (int j = 0; j < 3; j++) begin
        collect(1);
        if (state[1] !== 1'b0) bad++;
      end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bounce_state: got state[1]=1 in %0d cycles, required 0", bad); end
    @(posedge clk); #1 button_in[1] = 1'b1; c0 = cyc;
    expq.push_back(exp_t'{0, 1, c0 + 10, c0 + 16});
    collect(24);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1 button_in[1] = ~button_in[1]; c0 = cyc;
      collect(2);
    end
    expq.push_back(exp_t'{1, 1, c0 + 10, c0 + 16});
    collect(22);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL bounce: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL bounce: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL bounce_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
  endtask

  task automatic test_inversion();
    exp_t e; obs_t o; int mc[$]; int c0;
    tests++; if (state[3] !== 1'b0) begin fails++; $display("FAIL invert_idle: got state[3]=%b, required 0", state[3]); end
    @(posedge clk); #1 button_in[3] = 1'b0; c0 = cyc;
    expq.push_back(exp_t'{0, 3, c0 + 10, c0 + 16});
    collect(20);
    @(posedge clk); #1 button_in[3] = 1'b1; c0 = cyc;
    expq.push_back(exp_t'{1, 3, c0 + 10, c0 + 16});
    collect(20);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL inversion: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL inversion: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL inversion_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e; obs_t o; int mc[$]; int c0; int cr;
    @(posedge clk); #1 button_in[0] = 1'b1; c0 = cyc;
    expq.push_back(exp_t'{0, 0, c0 + 10, c0 + 16});
    collect(36);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; cr = cyc;
    @(negedge clk);
    tests++;
    if ({state, rise, fall, long_press, repeat_pulse} !== 20'h0) begin
      fails++; $display("FAIL mid_reset_outputs: got state=%b rise=%b fall=%b long=%b rep=%b, required all 0", state, rise, fall, long_press, repeat_pulse);
    end
    expq.push_back(exp_t'{0, 0, cr + 10, cr + 16});
    expq.push_back(exp_t'{2, 0, cr + 47, cr + 56});
    collect(cr + 58 - cyc);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL mid_reset: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL mid_reset: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL mid_reset_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
    if (mc.size() >= 3) begin
      tests++;
      if (mc[2] - mc[1] < 37 || mc[2] - mc[1] > 40) begin
        fails++; $display("FAIL mid_reset_long_delay: got %0d cycles after rise, required 37..40", mc[2] - mc[1]);
      end
    end
    // Return to a clean, released state for the next scenario.
    @(posedge clk); #1 button_in[0] = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    exp_t e; obs_t o; int mc[$]; int c0;
    @(posedge clk); #1 button_in[2] = 1'b1; c0 = cyc;
    expq.push_back(exp_t'{0, 2, c0 + 10, c0 + 16});
    collect(20);
    @(posedge clk); #1 button_in[0] = 1'b1; button_in[2] = 1'b0; c0 = cyc;
    expq.push_back(exp_t'{0, 0, c0 + 10, c0 + 16});
    expq.push_back(exp_t'{1, 2, c0 + 10, c0 + 16});
    collect(20);
    while (expq.size() > 0) begin
      e = expq.pop_front(); tests++;
      if (obsq.size() == 0) begin
        fails++; $display("FAIL simultaneous: %s ch%0d got none, required at cycle %0d..%0d", kname[e.kind], e.ch, e.lo, e.hi);
      end else begin
        o = obsq.pop_front(); mc.push_back(o.cyc);
        if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
          fails++; $display("FAIL simultaneous: got %s ch%0d at %0d, required %s ch%0d at %0d..%0d", kname[o.kind], o.ch, o.cyc, kname[e.kind], e.ch, e.lo, e.hi);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++; $display("FAIL simultaneous_extra: got %0d extra pulses (first %s ch%0d at %0d), required 0", obsq.size(), kname[obsq[0].kind], obsq[0].ch, obsq[0].cyc);
      obsq.delete();
    end
    tests++;
    if (mc.size() < 3 || mc[1] != mc[2]) begin
      fails++; $display("FAIL simultaneous_same_cycle: got %0d pulses (rise0/fall2 cycles differ or missing), required same cycle", mc.size());
    end
    tests++; if (state !== 4'b0001) begin fails++; $display("FAIL simultaneous_state: got %b, required 0001", state); end
    tests++; if (both_err != 0) begin fails++; $display("FAIL rise_fall_overlap: got %0d overlaps, required 0", both_err); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_long_press();
    test_bounce();
    test_inversion();
    test_reset_mid_hold();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
